// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses pll_rst, qualifies a synchronized lock, then releases sys_rst.
// Outputs are registered alongside the state (no extra lag); no backpressure, locked_in is sampled every refclk.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_in,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sync_q;
  logic            lock_s;
  logic [3:0]      retry_d;
  logic [7:0]      loss_d;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], locked_in};
    end
  end

  assign lock_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_count;
    loss_d  = lock_loss_count;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_count == RETRY_MAX) begin
            state_d = FAULT;
          end else begin
            retry_d = retry_count + 4'd1;
            state_d = RESET_PLL;
          end
        end
      end
      STABLE: begin
        // A lock dropout only restarts qualification; retries are for timeouts.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = 4'd0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = RESET_PLL;
          if (lock_loss_count != 8'hFF) loss_d = lock_loss_count + 8'd1;
        end
      end
      FAULT: begin
        cnt_d = '0;
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q         <= RESET_PLL;
      cnt_q           <= '0;
      retry_count     <= 4'd0;
      lock_loss_count <= 8'd0;
      pll_rst         <= 1'b1;
      sys_rst         <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      retry_count     <= retry_d;
      lock_loss_count <= loss_d;
      pll_rst         <= (state_d == RESET_PLL) || (state_d == FAULT);
      sys_rst         <= (state_d != RUN);
      ready           <= (state_d == RUN);
      fault           <= (state_d == FAULT);
    end
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16: cycles pll_rst is held high per PLL reset attempt (>=1).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: max cycles to wait for lock per attempt (>=2).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: PLL reset retries after the first attempt before FAULT (0..15).
REQ-005 SHALL have port refclk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port locked_in, input, 1: PLL lock indication, asynchronous to refclk.
REQ-008 SHALL have port pll_rst, output, 1: reset to the PLL, active-high.
REQ-009 SHALL have port sys_rst, output, 1: downstream logic reset, active-high.
REQ-010 SHALL have port ready, output, 1: high only in RUN.
REQ-011 SHALL have port fault, output, 1: high only in FAULT.
REQ-012 SHALL have port retry_count, output, 4: retries used in the current bring-up.
REQ-013 SHALL have port lock_loss_count, output, 8: lock losses seen in RUN, saturating.

Function
REQ-014 SHALL pass locked_in through a 2-flop synchronizer; lock_s is its output and is the only lock signal used.
REQ-015 SHALL implement FSM states RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT, with a single cycle counter cleared on every state change.
REQ-016 SHALL register all outputs, decoded from the registered state: RESET_PLL pll_rst=1 sys_rst=1; WAIT_LOCK and STABLE pll_rst=0 sys_rst=1; RUN pll_rst=0 sys_rst=0 ready=1; FAULT pll_rst=1 sys_rst=1 fault=1.
REQ-017 RESET_PLL SHALL last exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK.
REQ-018 WAIT_LOCK SHALL go to STABLE on the first cycle lock_s=1.
REQ-019 WAIT_LOCK SHALL time out after LOCK_TIMEOUT_CYCLES cycles with lock_s=0.
REQ-020 On timeout, WAIT_LOCK SHALL go to FAULT if retry_count==MAX_RETRIES; otherwise it SHALL increment retry_count and go to RESET_PLL.
REQ-021 STABLE SHALL go to RUN after LOCK_STABLE_CYCLES consecutive cycles of lock_s=1.
REQ-022 STABLE SHALL go to WAIT_LOCK, with its timeout restarted, on any lock_s=0; it SHALL NOT consume a retry.
REQ-023 RUN SHALL clear retry_count on entry.
REQ-024 RUN SHALL go to RESET_PLL on lock_s=0 and increment lock_loss_count, saturating at 255.
REQ-025 sys_rst SHALL be high in the first cycle of the resulting RESET_PLL state.
REQ-026 FAULT SHALL be terminal; only rst exits it.
REQ-027 Counters SHALL be sized by clog2 of their parameter and SHALL never wrap inside a state.
REQ-028 If rst and a state transition coincide, rst SHALL win.

Reset
REQ-029 While rst=1, the block SHALL hold state RESET_PLL, counter 0, synchronizer 0, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_count=0, lock_loss_count=0.
REQ-030 Asserting rst mid-operation, including in RUN or FAULT, SHALL restore the REQ-029 values at the next edge.
REQ-031 After rst falls, pll_rst SHALL stay high for exactly RST_PULSE_CYCLES further cycles.

Verification (params RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-032 Nominal: rst released; locked_in rises 3 cycles after pll_rst falls -> pll_rst high 4 cycles; ready=1 and sys_rst=0 exactly 2+8+1 cycles after locked_in rises (+/-1 for synchronizer phase, checked against model).
REQ-033 Glitch in STABLE: locked_in low 3 cycles midway -> return to WAIT_LOCK, retry_count stays 0; ready only after a fresh 8-cycle stable run.
REQ-034 Timeout to fault: locked_in held 0 -> three pll_rst pulses of 4 cycles; retry_count 1 then 2; then fault=1, pll_rst=1, sys_rst=1, held indefinitely.
REQ-035 Lock loss in RUN: locked_in drops -> ready=0 and sys_rst=1 within 3 cycles; lock_loss_count +1; 256 losses leave lock_loss_count=255.
REQ-036 rst in FAULT and in RUN: rst pulsed 1 cycle -> all outputs at REQ-029 values the next cycle; normal bring-up follows.
